fu_issue_scheduler: RTL and testbench

- Per-cycle issue arbiter between reservation-station (RS) entries and the functional units.
- Consumes the 3-bit FU class produced by the instruction decoder per RS entry: 000 ALU, 001 MULT, 011 MEM, 100 BR.
- Grants at most one entry per class per cycle using per-class round-robin priority.
- Tracks occupancy of the pipelined multiplier and the non-pipelined memory unit.

---
 rtl/fu_issue_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_fu_issue_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// fu_issue_scheduler
//
// Per-cycle issue arbiter between the reservation-station entries and the
// functional units. Each RS entry carries a 3-bit FU class from the decoder:
//   000 ALU, 001 MULT, 011 MEM, 100 BR (every other code is never issued).
// At most one entry per class is granted per cycle, chosen by a per-class
// round-robin pointer. The block also tracks the pipelined multiplier (a
// valid shift register) and the non-pipelined memory unit (IDLE/BUSY FSM).
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset (0 = in reset)
//   rs_ready       entry i has its operands and is waiting to issue
//   rs_fu          FU class of entry i in bits [3i+2:3i]
//   issue_stall    global hold, no grants this cycle
//   squash         pipeline flush, kills in-flight MULT/MEM tracking
//   mem_done       memory unit finished its current operation
//   grant_vec      OR of all class grants, one bit per entry
//   *_issue        class grant valid this cycle (alu/br/mult/mem)
//   *_idx          granted entry index, 0 when the matching issue is low
//   mult_done      a multiply completes this cycle
//   mult_inflight  number of multiplies currently in the pipe
//   mem_busy       memory unit occupied
// ---------------------------------------------------------------------------
module fu_issue_scheduler #(
  parameter int NUM_RS   = 8,
  parameter int MULT_LAT = 4,
  parameter int IDX_W    = $clog2(NUM_RS),
  parameter int CNT_W    = $clog2(MULT_LAT + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_RS-1:0]     rs_ready,
  input  logic [3*NUM_RS-1:0]   rs_fu,
  input  logic                  issue_stall,
  input  logic                  squash,
  input  logic                  mem_done,
  output logic [NUM_RS-1:0]     grant_vec,
  output logic                  alu_issue,
  output logic                  br_issue,
  output logic                  mult_issue,
  output logic                  mem_issue,
  output logic [IDX_W-1:0]      alu_idx,
  output logic [IDX_W-1:0]      br_idx,
  output logic [IDX_W-1:0]      mult_idx,
  output logic [IDX_W-1:0]      mem_idx,
  output logic                  mult_done,
  output logic [CNT_W-1:0]      mult_inflight,
  output logic                  mem_busy
);

  localparam logic [2:0] FU_ALU  = 3'b000;
  localparam logic [2:0] FU_MULT = 3'b001;
  localparam logic [2:0] FU_MEM  = 3'b011;
  localparam logic [2:0] FU_BR   = 3'b100;

  // Arbiter slots, one per issuable class.
  localparam int C_ALU  = 0;
  localparam int C_MULT = 1;
  localparam int C_MEM  = 2;
  localparam int C_BR   = 3;
  localparam int NCLS   = 4;

  typedef enum logic {
    MEM_IDLE,
    MEM_BUSY
  } mem_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  logic [IDX_W-1:0]    ptr_q   [NCLS];
  logic [IDX_W-1:0]    ptr_d   [NCLS];
  logic [NUM_RS-1:0]   req     [NCLS];
  pick_t               pick    [NCLS];
  logic [NCLS-1:0]     grant;
  logic [MULT_LAT-1:0] multSr_q;
  logic [MULT_LAT-1:0] multSr_d;
  mem_state_e          memState_q;
  logic                memBusy_q;
  logic                allowIssue;
  logic                memAvail;

  // Round-robin pick: first requester at or above ptr, wrapping modulo
  // NUM_RS. The scan runs from the largest offset down so the smallest
  // offset is the last (and therefore winning) assignment.
  function automatic pick_t rrPick(input logic [NUM_RS-1:0] reqVec,
                                   input logic [IDX_W-1:0]  ptr);
    pick_t p;
    int    j;
    p = '0;
    for (int k = NUM_RS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_RS) begin
        j = j - NUM_RS;
      end
      if (reqVec[j]) begin
        p.found = 1'b1;
        p.idx   = IDX_W'(j);
      end
    end
    return p;
  endfunction

  // Split the ready vector into one request vector per class. Entries with
  // an unknown class appear in no vector, so they never block anyone.
  always_comb begin
    for (int c = 0; c < NCLS; c++) begin
      req[c] = '0;
    end
    for (int i = 0; i < NUM_RS; i++) begin
      req[C_ALU][i]  = rs_ready[i] && (rs_fu[3*i +: 3] == FU_ALU);
      req[C_MULT][i] = rs_ready[i] && (rs_fu[3*i +: 3] == FU_MULT);
      req[C_MEM][i]  = rs_ready[i] && (rs_fu[3*i +: 3] == FU_MEM);
      req[C_BR][i]   = rs_ready[i] && (rs_fu[3*i +: 3] == FU_BR);
    end
  end

  // Grant generation. Reset, stall and squash all gate every class; the
  // memory unit additionally needs to be idle or finishing this cycle, which
  // is what allows back-to-back memory operations.
  always_comb begin
    allowIssue = reset && !issue_stall && !squash;
    memAvail   = (memState_q == MEM_IDLE) || mem_done;
    for (int c = 0; c < NCLS; c++) begin
      pick[c]  = rrPick(req[c], ptr_q[c]);
      grant[c] = allowIssue && pick[c].found;
    end
    grant[C_MEM] = grant[C_MEM] && memAvail;
  end

  // Output decode. Each entry has exactly one class, so the bits OR-ed into
  // grant_vec always land on distinct entries.
  always_comb begin
    grant_vec = '0;
    for (int c = 0; c < NCLS; c++) begin
      if (grant[c]) begin
        grant_vec[pick[c].idx] = 1'b1;
      end
    end
    alu_issue  = grant[C_ALU];
    mult_issue = grant[C_MULT];
    mem_issue  = grant[C_MEM];
    br_issue   = grant[C_BR];
    alu_idx    = grant[C_ALU]  ? pick[C_ALU].idx  : '0;
    mult_idx   = grant[C_MULT] ? pick[C_MULT].idx : '0;
    mem_idx    = grant[C_MEM]  ? pick[C_MEM].idx  : '0;
    br_idx     = grant[C_BR]   ? pick[C_BR].idx   : '0;
  end

  // Pointer update: move just past the winner, wrapping at the last entry.
  // Classes without a grant (including stall/squash cycles) keep their ptr.
  always_comb begin
    for (int c = 0; c < NCLS; c++) begin
      ptr_d[c] = ptr_q[c];
      if (grant[c]) begin
        ptr_d[c] = (pick[c].idx == IDX_W'(NUM_RS - 1)) ? '0
                                                         : pick[c].idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCLS; c++) begin
        ptr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCLS; c++) begin
        ptr_q[c] <= ptr_d[c];
      end
    end
  end

  // Multiplier occupancy: stage 0 is loaded by this cycle's grant and the
  // last stage is the completion strobe, giving MULT_LAT cycles of latency.
  // A squash empties the whole pipe at the next edge.
  always_comb begin
    multSr_d = {multSr_q[MULT_LAT-2:0], mult_issue};
    if (squash) begin
      multSr_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      multSr_q <= '0;
    end else begin
      multSr_q <= multSr_d;
    end
  end

  assign mult_done = multSr_q[MULT_LAT-1];

  // Population count of the valid bits. An issue and a completion in the
  // same cycle shift one bit in and one out, so the count naturally holds.
  always_comb begin
    mult_inflight = '0;
    for (int i = 0; i < MULT_LAT; i++) begin
      mult_inflight = mult_inflight + CNT_W'(multSr_q[i]);
    end
  end

  // Memory unit FSM with a registered busy flag. Squash wins over both a
  // new grant and mem_done; mem_done while idle has no effect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memState_q <= MEM_IDLE;
      memBusy_q  <= 1'b0;
    end else if (squash) begin
      memState_q <= MEM_IDLE;
      memBusy_q  <= 1'b0;
    end else begin
      case (memState_q)
        MEM_IDLE: begin
          if (mem_issue) begin
            memState_q <= MEM_BUSY;
            memBusy_q  <= 1'b1;
          end
        end
        MEM_BUSY: begin
          if (mem_done && !mem_issue) begin
            memState_q <= MEM_IDLE;
            memBusy_q  <= 1'b0;
          end
        end
        default: begin
          memState_q <= MEM_IDLE;
          memBusy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_busy = memBusy_q;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fu_issue_scheduler
//
// Self-checking bench for fu_issue_scheduler (NUM_RS=8, MULT_LAT=4).
// A behavioural model tracks per-class pointers as integers, multiplies as a
// queue of issue cycle numbers, and the memory unit as a single busy bit.
// Every cycle all outputs are compared against it, and the directed steps
// add a few literal expectations on top.
// ---------------------------------------------------------------------------
module tb_fu_issue_scheduler;

  localparam int NUM_RS   = 8;
  localparam int MULT_LAT = 4;
  localparam int IDX_W    = 3;
  localparam int CNT_W    = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [NUM_RS-1:0]   rs_ready = '0;
  logic [3*NUM_RS-1:0] rs_fu = '0;
  logic                issue_stall = 1'b0;
  logic                squash = 1'b0;
  logic                mem_done = 1'b0;
  logic [NUM_RS-1:0]   grant_vec;
  logic                alu_issue, br_issue, mult_issue, mem_issue;
  logic [IDX_W-1:0]    alu_idx, br_idx, mult_idx, mem_idx;
  logic                mult_done;
  logic [CNT_W-1:0]    mult_inflight;
  logic                mem_busy;

  always #5 clock = ~clock;

  fu_issue_scheduler #(.NUM_RS(NUM_RS), .MULT_LAT(MULT_LAT)) dut (
    .clock         (clock),
    .reset         (reset),
    .rs_ready      (rs_ready),
    .rs_fu         (rs_fu),
    .issue_stall   (issue_stall),
    .squash        (squash),
    .mem_done      (mem_done),
    .grant_vec     (grant_vec),
    .alu_issue     (alu_issue),
    .br_issue      (br_issue),
    .mult_issue    (mult_issue),
    .mem_issue     (mem_issue),
    .alu_idx       (alu_idx),
    .br_idx        (br_idx),
    .mult_idx      (mult_idx),
    .mem_idx       (mem_idx),
    .mult_done     (mult_done),
    .mult_inflight (mult_inflight),
    .mem_busy      (mem_busy)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  int mPtr[4];
  int mMultQ[$];
  bit mMemBusy;
  int now;

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int classCode(input int c);
    case (c)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [23:0] mkFu(input int f[8]);
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v = v | (24'(f[i] & 7) << (3 * i));
    end
    return v;
  endfunction

  function automatic int modelPick(input int c, input logic [7:0] rdy,
                                   input logic [23:0] fu);
    int i;
    for (int k = 0; k < NUM_RS; k++) begin
      i = (mPtr[c] + k) % NUM_RS;
      if (rdy[i] && (int'((fu >> (3 * i)) & 24'd7) == classCode(c))) begin
        return i;
      end
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < 4; c++) mPtr[c] = 0;
    mMultQ.delete();
    mMemBusy = 1'b0;
  endtask

  // One clock cycle: drive just after the rising edge, compare on the
  // falling edge, then advance the model. Returns at the falling edge so the
  // caller can add literal checks on the same cycle.
  task automatic applyStimulus(input logic [7:0] rdy, input logic [23:0] fu,
                               input logic st, input logic sq,
                               input logic md);
    int          win[4];
    logic [7:0]  expVec;
    int          expDone;
    int          expInfl;
    @(posedge clock);
    #1;
    rs_ready    = rdy;
    rs_fu       = fu;
    issue_stall = st;
    squash      = sq;
    mem_done    = md;
    @(negedge clock);
    expVec = '0;
    for (int c = 0; c < 4; c++) begin
      win[c] = (st || sq) ? -1 : modelPick(c, rdy, fu);
      if (c == 2 && mMemBusy && !md) win[c] = -1;
      if (win[c] >= 0) expVec[win[c]] = 1'b1;
    end
    expDone = 0;
    expInfl = 0;
    foreach (mMultQ[q]) begin
      if (now - mMultQ[q] == MULT_LAT) expDone = 1;
      if (now - mMultQ[q] >= 1 && now - mMultQ[q] <= MULT_LAT) expInfl++;
    end
    checkOutput(expVec, win, expDone, expInfl);
    if (sq) begin
      mMultQ.delete();
      mMemBusy = 1'b0;
    end else begin
      if (win[1] >= 0) mMultQ.push_back(now);
      if (win[2] >= 0) mMemBusy = 1'b1;
      else if (md) mMemBusy = 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      if (win[c] >= 0) mPtr[c] = (win[c] + 1) % NUM_RS;
    end
    now++;
  endtask

  task automatic checkOutput(input logic [7:0] expVec, input int win[4],
                             input int expDone, input int expInfl);
    checkVal("grant_vec",     grant_vec,  expVec);
    checkVal("alu_issue",     alu_issue,  win[0] >= 0);
    checkVal("alu_idx",       alu_idx,    win[0] >= 0 ? win[0] : 0);
    checkVal("mult_issue",    mult_issue, win[1] >= 0);
    checkVal("mult_idx",      mult_idx,   win[1] >= 0 ? win[1] : 0);
    checkVal("mem_issue",     mem_issue,  win[2] >= 0);
    checkVal("mem_idx",       mem_idx,    win[2] >= 0 ? win[2] : 0);
    checkVal("br_issue",      br_issue,   win[3] >= 0);
    checkVal("br_idx",        br_idx,     win[3] >= 0 ? win[3] : 0);
    checkVal("mult_done",     mult_done,  expDone);
    checkVal("mult_inflight", mult_inflight, expInfl);
    checkVal("mem_busy",      mem_busy,   mMemBusy);
  endtask

  initial begin
    int fuTab[8];
    logic [23:0] fuMix;

    // Reset with every entry ready as ALU: nothing may be granted.
    modelReset();
    now      = 0;
    rs_ready = 8'hFF;
    rs_fu    = 24'o00000000;
    #12;
    checkVal("rst_grant_vec", grant_vec, 0);
    checkVal("rst_alu_issue", alu_issue, 0);
    checkVal("rst_mult_done", mult_done, 0);
    checkVal("rst_inflight",  mult_inflight, 0);
    checkVal("rst_mem_busy",  mem_busy, 0);
    rs_ready = '0;
    @(negedge clock);
    reset = 1'b1;
    $display("[TB] reset released");

    // ALU round robin between entries 0 and 2.
    applyStimulus(8'b0000_0101, 24'o00000000, 0, 0, 0);
    checkVal("rr_alu_idx_c1", alu_idx, 0);
    applyStimulus(8'b0000_0101, 24'o00000000, 0, 0, 0);
    checkVal("rr_alu_idx_c2", alu_idx, 2);
    applyStimulus(8'b0000_0101, 24'o00000000, 0, 0, 0);
    checkVal("rr_alu_idx_c3", alu_idx, 0);

    // All four classes at once.
    fuTab = '{7, 1, 7, 3, 4, 7, 0, 7};
    fuMix = mkFu(fuTab);
    applyStimulus(8'b0101_1010, fuMix, 0, 0, 0);
    checkVal("all4_grant_vec", grant_vec, 8'h5A);
    checkVal("all4_mult_idx",  mult_idx, 1);
    checkVal("all4_mem_idx",   mem_idx, 3);
    checkVal("all4_br_idx",    br_idx, 4);
    checkVal("all4_alu_idx",   alu_idx, 6);
    applyStimulus(8'h00, fuMix, 0, 0, 1);
    for (int n = 0; n < 5; n++) applyStimulus(8'h00, fuMix, 0, 0, 0);

    // Three back-to-back multiplies.
    for (int cyc = 0; cyc < 8; cyc++) begin
      applyStimulus(cyc < 3 ? 8'h01 : 8'h00, 24'o11111111, 0, 0, 0);
      if (cyc >= 4 && cyc <= 6) checkVal("mult_done_seq", mult_done, 1);
      if (cyc == 3) checkVal("mult_peak", mult_inflight, 3);
      if (cyc == 7) checkVal("mult_drained", mult_inflight, 0);
    end

    // Memory unit busy, then back-to-back issue on mem_done.
    for (int cyc = 0; cyc < 7; cyc++) begin
      applyStimulus(cyc < 6 ? 8'h03 : 8'h00, 24'o33333333, 0, 0,
                    (cyc == 5 || cyc == 6));
      if (cyc == 0) checkVal("mem_first", mem_issue, 1);
      if (cyc >= 1 && cyc <= 4) checkVal("mem_blocked", mem_issue, 0);
      if (cyc == 5) checkVal("mem_b2b", mem_issue, 1);
      if (cyc == 6) checkVal("mem_still_busy", mem_busy, 1);
    end
    applyStimulus(8'h00, 24'o33333333, 0, 0, 0);

    // Squash with multiplies and a memory op in flight.
    fuTab = '{1, 0, 3, 7, 7, 7, 7, 7};
    fuMix = mkFu(fuTab);
    applyStimulus(8'b0000_0101, fuMix, 0, 0, 0);
    applyStimulus(8'b0000_0001, fuMix, 0, 0, 0);
    applyStimulus(8'b0000_0111, fuMix, 0, 1, 0);
    checkVal("squash_no_grant", grant_vec, 0);
    for (int cyc = 0; cyc < 5; cyc++) begin
      applyStimulus(8'h00, fuMix, 0, 0, 0);
      if (cyc == 0) checkVal("squash_inflight", mult_inflight, 0);
      if (cyc == 0) checkVal("squash_mem_busy", mem_busy, 0);
      checkVal("squash_no_done", mult_done, 0);
    end

    // Unknown class never issues.
    for (int cyc = 0; cyc < 10; cyc++) begin
      applyStimulus(8'b0010_0000, 24'o77777777, 0, 0, 0);
      checkVal("class7_none", grant_vec, 0);
    end

    // Stall holds grants and pointers.
    applyStimulus(8'b0000_0101, 24'o00000000, 1, 0, 0);
    checkVal("stall_alu", alu_issue, 0);
    applyStimulus(8'b0000_0101, 24'o00000000, 1, 0, 0);
    applyStimulus(8'b0000_0101, 24'o00000000, 0, 0, 0);

    // Asynchronous reset in the middle of a memory operation.
    applyStimulus(8'h08, 24'o33333333, 0, 0, 0);
    checkVal("pre_rst_mem_issue", mem_issue, 1);
    @(posedge clock);
    #1;
    rs_ready = 8'hFF;
    rs_fu    = 24'o00000000;
    #1;
    reset = 1'b0;
    #1;
    checkVal("async_mem_busy",  mem_busy, 0);
    checkVal("async_grant_vec", grant_vec, 0);
    modelReset();
    now++;
    @(negedge clock);
    rs_ready = '0;
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(8'h10, 24'o00000000, 0, 0, 0);
    checkVal("post_rst_alu_idx", alu_idx, 4);

    // Randomized traffic, including unknown classes, stalls and squashes.
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [7:0]  rdy;
      logic [23:0] fu;
      rdy = 8'($urandom);
      fu  = 24'($urandom);
      applyStimulus(rdy, fu, ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
